// File: rtl/multu_hilo_pkg.sv
// Shared funct codes and multiplier FSM encoding.
// Imported by the HI/LO multiplier and the result-select mux.
package multu_hilo_pkg;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'd25;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/multu_step.sv
// One shift-add iteration of the unsigned multiplier.
// The adder carry lands in the product MSB on the shift.
module multu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] nxt
);

    logic [WIDTH:0] s;

    // conditional add of the multiplicand, then shift right by one
    always_comb begin
        s = {1'b0, prod[2*WIDTH-1:WIDTH]};
        if (prod[0]) begin
            s = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
        nxt = {s, prod[WIDTH-1:1]};
    end

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned multiplier owning the HI/LO pair.
// HI/LO change only on the edge that ends the last iteration.
module multu_hilo
    import multu_hilo_pkg::*;
#(
    parameter int         WIDTH       = 32,
    parameter logic [5:0] MULTU_FUNCT = F_MULTU
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] nxt;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;

    multu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .prod (prod),
        .mcand(mcand),
        .nxt  (nxt)
    );

    // control FSM, iteration counter and HI/LO commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            prod  <= '0;
            mcand <= '0;
            cnt   <= '0;
            HiOut <= '0;
            LoOut <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (Signal == MULTU_FUNCT) begin
                        mcand <= dataA;
                        prod  <= {{WIDTH{1'b0}}, dataB};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    prod <= nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        HiOut <= nxt[2*WIDTH-1:WIDTH];
                        LoOut <= nxt[WIDTH-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multu_hilo.sv
// Directed bench for the HI/LO multiplier.
// Each task drives one scenario and checks inline.
module tb_multu_hilo;

    logic        clk;
    logic        rst_n;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    // start edge is sampled one negedge after driving; 32 iterations
    // then put done on the 33rd negedge counted from the drive
    localparam int LAT = 33;

    multu_hilo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dataA (dataA),
        .dataB (dataB),
        .Signal(Signal),
        .HiOut (HiOut),
        .LoOut (LoOut),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        @(negedge clk);
        dataA  = a;
        dataB  = b;
        Signal = 6'd25;
        @(negedge clk);
        Signal = 6'd0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        Signal = 6'd25;
        repeat (3) @(negedge clk);
        tests++;
        if (HiOut !== 32'd0) begin
            fails++;
            $display("FAIL reset_hi got=%h exp=0", HiOut);
        end
        tests++;
        if (LoOut !== 32'd0) begin
            fails++;
            $display("FAIL reset_lo got=%h exp=0", LoOut);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got=%b%b exp=00", busy, done);
        end
        Signal = 6'd0;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle busy=%b exp=0", busy);
        end
    endtask

    task automatic test_basic;
        int cyc;
        @(negedge clk);
        dataA  = 32'd3;
        dataB  = 32'd5;
        Signal = 6'd25;
        @(negedge clk);
        Signal = 6'd0;
        cyc = 1;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy got=%b exp=1", busy);
        end
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (cyc != LAT) begin
            fails++;
            $display("FAIL basic_latency got=%0d exp=%0d", cyc, LAT);
        end
        tests++;
        if (HiOut !== 32'h0 || LoOut !== 32'hF) begin
            fails++;
            $display("FAIL basic_prod got=%h_%h exp=0_f", HiOut, LoOut);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy_end got=%b exp=0", busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_carry;
        int cyc;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        tests++;
        if (HiOut !== 32'hFFFF_FFFE || LoOut !== 32'h1) begin
            fails++;
            $display("FAIL carry_prod got=%h_%h exp=fffffffe_00000001",
                     HiOut, LoOut);
        end
    endtask

    task automatic test_zero_mixed;
        int cyc;
        run_op(32'h0, 32'h1234_5678, cyc);
        tests++;
        if (HiOut !== 32'h0 || LoOut !== 32'h0) begin
            fails++;
            $display("FAIL zero_prod got=%h_%h exp=0_0", HiOut, LoOut);
        end
        run_op(32'h8000_0000, 32'h2, cyc);
        tests++;
        if (HiOut !== 32'h1 || LoOut !== 32'h0) begin
            fails++;
            $display("FAIL mixed_prod got=%h_%h exp=1_0", HiOut, LoOut);
        end
    endtask

    task automatic test_hold_ignore;
        int cyc;
        bit stale_bad;
        run_op(32'd3, 32'd5, cyc);
        stale_bad = 1'b0;
        @(negedge clk);
        dataA  = 32'd7;
        dataB  = 32'd9;
        Signal = 6'd25;
        @(negedge clk);
        Signal = 6'd0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (HiOut !== 32'd0 || LoOut !== 32'd15) stale_bad = 1'b1;
            if (cyc == 5) begin
                dataA = 32'hDEAD_BEEF;
                dataB = 32'h0BAD_F00D;
            end
            if (cyc == 8) Signal = 6'd25;
            if (cyc == 9) Signal = 6'd0;
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (stale_bad) begin
            fails++;
            $display("FAIL hold_stale got=changed exp=0_f");
        end
        tests++;
        if (HiOut !== 32'd0 || LoOut !== 32'd63) begin
            fails++;
            $display("FAIL hold_prod got=%h_%h exp=0_3f", HiOut, LoOut);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_no_restart busy=%b exp=0", busy);
        end
    endtask

    task automatic test_mid_reset;
        int cyc;
        @(negedge clk);
        dataA  = 32'd5;
        dataB  = 32'd6;
        Signal = 6'd25;
        @(negedge clk);
        Signal = 6'd0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (HiOut !== 32'd0 || LoOut !== 32'd0) begin
            fails++;
            $display("FAIL midrst_hilo got=%h_%h exp=0_0", HiOut, LoOut);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midrst_flags got=%b%b exp=00", busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || LoOut !== 32'd0) begin
            fails++;
            $display("FAIL midrst_idle got=%b_%h exp=0_0", busy, LoOut);
        end
        run_op(32'd6, 32'd7, cyc);
        tests++;
        if (cyc != LAT) begin
            fails++;
            $display("FAIL midrst_latency got=%0d exp=%0d", cyc, LAT);
        end
        tests++;
        if (HiOut !== 32'd0 || LoOut !== 32'd42) begin
            fails++;
            $display("FAIL midrst_prod got=%h_%h exp=0_2a", HiOut, LoOut);
        end
    endtask

    task automatic test_back_to_back;
        int t[3];
        int k;
        bit lo_bad;
        k = 0;
        lo_bad = 1'b0;
        repeat (3) @(negedge clk);
        dataA  = 32'd2;
        dataB  = 32'd4;
        Signal = 6'd25;
        for (int i = 0; i < 200 && k < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t[k] = i;
                if (LoOut !== 32'd8 || HiOut !== 32'd0) lo_bad = 1'b1;
                k++;
            end
        end
        Signal = 6'd0;
        tests++;
        if (k != 3) begin
            fails++;
            $display("FAIL b2b_pulses got=%0d exp=3", k);
        end else begin
            tests++;
            if (t[1] - t[0] != 34) begin
                fails++;
                $display("FAIL b2b_period1 got=%0d exp=34", t[1] - t[0]);
            end
            tests++;
            if (t[2] - t[1] != 34) begin
                fails++;
                $display("FAIL b2b_period2 got=%0d exp=34", t[2] - t[1]);
            end
        end
        tests++;
        if (lo_bad) begin
            fails++;
            $display("FAIL b2b_prod got=bad exp=0_8");
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_carry();
        test_zero_mixed();
        test_hold_ignore();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
